cook_ctrl: RTL and testbench
============================

# cook_ctrl

Sequencing controller for the microwave timer datapath. Turns the debounced centre/up/down button levels into cook-time setting, start/pause/resume and countdown. Drives the motor run enable and the one-hot state that selects between the countdown and finish-animation displays. Sits between the debounce instances and the FND controllers/FND select mux, and takes the finish-animation done pulse back.

## Interface
Parameters:
- CLK_HZ, 100_000_000: clock frequency; sets the 1 s tick period.
- STEP_SEC, 10: seconds added/removed per up/down press.
- MAX_SEC, 999: saturation limit of the cook time.
- SEC_W, $clog2(MAX_SEC+1): width of the seconds count (10 at default).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- btn_start  in  1  debounced centre button (BTNC) level.
- btn_up  in  1  debounced up button (BTNU) level.
- btn_down  in  1  debounced down button (BTND) level.
- finish  in  1  one-cycle pulse from the finish-animation block: animation complete.
- o_sec  out  SEC_W  remaining/set seconds, to the countdown FND.
- o_run  out  1  motor enable; high only in RUN.
- o_state  out  4  one-hot state: [0] IDLE, [1] RUN, [2] PAUSE, [3] DONE. Bit 3 drives the FND select.
- door_open  in  1  only when COOK_DOOR_EN is defined; 1 = door open.

## Operation
- Button inputs are registered once, then rising-edge detected internally. Each press is one event regardless of hold length.
- Reset values: state IDLE, o_state=4'b0001, o_sec=0, o_run=0, prescaler=0, edge registers=0.
- IDLE:
  - up: o_sec = min(o_sec+STEP_SEC, MAX_SEC).
  - down: o_sec = (o_sec>STEP_SEC) ? o_sec-STEP_SEC : 0.
  - start with o_sec≠0: go to RUN. Start with o_sec=0 is ignored.
- RUN:
  - o_run=1.
  - On each 1 s tick, o_sec decrements.
  - Tick with o_sec==1: o_sec=0 and go to DONE on the same edge.
  - start: go to PAUSE.
  - up/down: ignored.
- PAUSE:
  - o_run=0; o_sec is frozen.
  - start: go to RUN.
  - up/down: same arithmetic as in IDLE.
  - down reaching 0: go to IDLE.
- DONE:
  - o_run=0; o_sec=0.
  - finish pulse or any button press: go to IDLE.
- Simultaneous events:
  - up and down in the same cycle: both ignored.
  - start together with up/down: start wins, up/down are discarded.
  - In RUN, start and tick in the same cycle: pause wins, and the tick is discarded (no decrement).
  - finish outside DONE: ignored.
- Arithmetic is unsigned, SEC_W wide. The add is computed at SEC_W+1 bits before the saturation compare, so there is no wrap.

## Timing
- Input to event: button level change → edge event 2 cycles later (one sync register plus one edge register). State/o_sec update on the following clock edge, so the effect is visible 3 cycles after the input.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN; tick is asserted when the count equals CLK_HZ-1.
  - Cleared on every entry to RUN, so the first decrement comes exactly CLK_HZ cycles after entry. Resume after pause restarts a full second.
- o_run and o_state are registered and change on the same edge as the state.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.
- finish is sampled directly, with no edge detect; a 1-cycle pulse is sufficient.

## Configuration
- COOK_DOOR_EN defined:
  - door_open port exists.
  - RUN with door_open=1 → PAUSE on the next edge.
  - start in IDLE/PAUSE is ignored while door_open=1.
  - door_open has no effect in DONE.
- COOK_DOOR_EN undefined: no door_open port; behaviour exactly as in Operation.

## Structure
- Package cook_pkg holds:
  - state encodings ST_IDLE=4'b0001, ST_RUN=4'b0010, ST_PAUSE=4'b0100, ST_DONE=4'b1000;
  - default STEP_SEC and MAX_SEC constants.
- One sub-module, cook_tick_gen: parameter CLK_HZ, inputs clk/reset/clr/en, output tick.
- The FSM, edge detectors and seconds arithmetic stay in cook_ctrl.

## Test plan
All scenarios use CLK_HZ=10.
- Set and saturate: 3 up presses → o_sec=30. 105 up presses → o_sec=999; one more up → still 999.
- Down floor: o_sec=25, 3 down presses → 15, 5, 0. Start at 0 → stays IDLE, o_state=0001.
- Countdown: o_sec=2, start → o_state=0010, o_run=1.
  - o_sec=1 at 10 cycles after RUN entry.
  - At 20 cycles: o_sec=0, o_state=1000, o_run=0.
  - finish pulse → o_state=0001.
- Pause/resume: RUN with o_sec=30, start after 5 cycles → PAUSE, o_sec=30, o_run=0. Up → 40. Start → RUN; first decrement to 39 exactly 10 cycles later.
- Conflicts: up+down in the same cycle → o_sec unchanged. Start+tick in the same cycle → PAUSE, o_sec unchanged.
- Reset mid-RUN (o_sec=17): reset low → o_sec=0, o_run=0, o_state=0001 without a clock edge.
- With COOK_DOOR_EN: door_open=1 in RUN → PAUSE. Start while the door is open → no change.

Source files
------------

// File: rtl/cook_pkg.sv
// Shared state encodings and default timing constants for the cook controller.
package cook_pkg;

  // One-hot so the state register can drive o_state directly.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_PAUSE = 4'b0100,
    ST_DONE  = 4'b1000
  } cook_state_e;

  localparam int unsigned STEP_SEC_DEF = 10;
  localparam int unsigned MAX_SEC_DEF  = 999;

endpackage

// File: rtl/cook_tick_gen.sv
// One-second prescaler: pulses tick for one cycle every CLK_HZ enabled cycles.
module cook_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && (cnt_q == CntMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/cook_ctrl.sv
// Microwave sequencing controller: cook-time setting, start/pause/resume and countdown.
// Optional door interlock enabled by defining COOK_DOOR_EN (adds the door_open port).
module cook_ctrl
  import cook_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned STEP_SEC = STEP_SEC_DEF,
  parameter int unsigned MAX_SEC  = MAX_SEC_DEF,
  parameter int unsigned SEC_W    = $clog2(MAX_SEC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             finish,
  output logic [SEC_W-1:0] o_sec,
  output logic             o_run,
  output logic [3:0]       o_state
`ifdef COOK_DOOR_EN
  ,
  input  logic             door_open
`endif
);

  localparam logic [SEC_W:0] StepW = (SEC_W + 1)'(STEP_SEC);
  localparam logic [SEC_W:0] MaxW  = (SEC_W + 1)'(MAX_SEC);

  cook_state_e state_q;

  // Bit order {start, up, down}; evt_q holds one-cycle press pulses.
  logic [2:0] sync_q, prev_q, evt_q;
  logic       ev_start, ev_up, ev_down, up_ok, dn_ok;
  logic       tick, door_hold;
  logic [SEC_W:0]   sum_w;
  logic [SEC_W-1:0] sec_up, sec_dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      sync_q <= {btn_start, btn_up, btn_down};
      prev_q <= sync_q;
      evt_q  <= sync_q & ~prev_q;
    end
  end

  assign ev_start = evt_q[2];
  assign ev_up    = evt_q[1];
  assign ev_down  = evt_q[0];
  // Start wins over up/down; opposing up+down cancel.
  assign up_ok    = ev_up & ~ev_down & ~ev_start;
  assign dn_ok    = ev_down & ~ev_up & ~ev_start;

`ifdef COOK_DOOR_EN
  assign door_hold = door_open;
`else
  assign door_hold = 1'b0;
`endif

  always_comb begin
    sum_w  = {1'b0, o_sec} + StepW;
    sec_up = (sum_w > MaxW) ? MaxW[SEC_W-1:0] : sum_w[SEC_W-1:0];
    sec_dn = ({1'b0, o_sec} > StepW) ? (o_sec - StepW[SEC_W-1:0]) : '0;
  end

  // Held clear outside RUN, so every RUN entry starts a full second.
  cook_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q != ST_RUN),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  assign o_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      o_sec   <= '0;
      o_run   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev_start) begin
            if ((o_sec != '0) && !door_hold) begin
              state_q <= ST_RUN;
              o_run   <= 1'b1;
            end
          end else if (up_ok) begin
            o_sec <= sec_up;
          end else if (dn_ok) begin
            o_sec <= sec_dn;
          end
        end
        ST_RUN: begin
          if (ev_start || door_hold) begin
            state_q <= ST_PAUSE;
            o_run   <= 1'b0;
          end else if (tick) begin
            if (o_sec <= SEC_W'(1)) begin
              o_sec   <= '0;
              state_q <= ST_DONE;
              o_run   <= 1'b0;
            end else begin
              o_sec <= o_sec - SEC_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (ev_start) begin
            if (!door_hold) begin
              state_q <= ST_RUN;
              o_run   <= 1'b1;
            end
          end else if (up_ok) begin
            o_sec <= sec_up;
          end else if (dn_ok) begin
            o_sec <= sec_dn;
            if (sec_dn == '0) state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          o_sec <= '0;
          o_run <= 1'b0;
          if (finish || (|evt_q)) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          o_sec   <= '0;
          o_run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cook_ctrl.sv
// Self-checking bench for cook_ctrl: directed scenarios plus random button traffic vs a reference model.
module tb_cook_ctrl;

  localparam int unsigned ClkHz = 10;
  localparam int Step   = 10;
  localparam int MaxSec = 999;
  localparam int SecW   = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, finish = 1'b0;
  logic [SecW-1:0] o_sec;
  logic            o_run;
  logic [3:0]      o_state;
`ifdef COOK_DOOR_EN
  logic door_open = 1'b0;
`endif

  always #5 clk = ~clk;

  cook_ctrl #(
    .CLK_HZ(ClkHz)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .finish   (finish),
    .o_sec    (o_sec),
    .o_run    (o_run),
    .o_state  (o_state)
`ifdef COOK_DOOR_EN
    ,
    .door_open(door_open)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 done; elapsed = edges spent in RUN since entry.
  int m_state, m_sec, m_elapsed;
  bit hs[3], hu[3], hd[3];

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_sec = 0;
    m_elapsed = 0;
    for (int i = 0; i < 3; i++) begin
      hs[i] = 1'b0;
      hu[i] = 1'b0;
      hd[i] = 1'b0;
    end
  endtask

  // A press takes effect two edges after the edge where its level is first sampled high.
  task automatic model_edge();
    bit s, u, d, door, tk, upd, dnd;
    s = hs[1] && !hs[2];
    u = hu[1] && !hu[2];
    d = hd[1] && !hd[2];
`ifdef COOK_DOOR_EN
    door = door_open;
`else
    door = 1'b0;
`endif
    upd = u && !d && !s;
    dnd = d && !u && !s;
    case (m_state)
      0: begin
        if (s) begin
          if (m_sec != 0 && !door) begin m_state = 1; m_elapsed = 0; end
        end else if (upd) m_sec = (m_sec + Step > MaxSec) ? MaxSec : m_sec + Step;
        else if (dnd) m_sec = (m_sec > Step) ? m_sec - Step : 0;
      end
      1: begin
        m_elapsed++;
        tk = (m_elapsed % ClkHz) == 0;
        if (s || door) m_state = 2;
        else if (tk) begin
          m_sec--;
          if (m_sec == 0) m_state = 3;
        end
      end
      2: begin
        if (s) begin
          if (!door) begin m_state = 1; m_elapsed = 0; end
        end else if (upd) m_sec = (m_sec + Step > MaxSec) ? MaxSec : m_sec + Step;
        else if (dnd) begin
          m_sec = (m_sec > Step) ? m_sec - Step : 0;
          if (m_sec == 0) m_state = 0;
        end
      end
      default: begin
        m_sec = 0;
        if (finish || s || u || d) m_state = 0;
      end
    endcase
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = btn_start;
    hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = btn_up;
    hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = btn_down;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("sec", int'(o_sec), m_sec);
    check_eq("run", int'(o_run), (m_state == 1) ? 1 : 0);
    check_eq("state", int'(o_state), 1 << m_state);
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_start = 1'b1;
      1: btn_up = 1'b1;
      default: btn_down = 1'b1;
    endcase
    cycle();
    btn_start = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    cycle();
  endtask

  // Falls between edges; outputs must clear without any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_sec", int'(o_sec), 0);
    check_eq("rst_run", int'(o_run), 0);
    check_eq("rst_state", int'(o_state), 1);
    btn_start = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    finish = 1'b0;
`ifdef COOK_DOOR_EN
    door_open = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    settle(2);

    // Set, then countdown from 10 s.
    press(1);
    settle(3);
    check_eq("set10", int'(o_sec), 10);
    press(0);
    cycle();
    check_eq("run_entry_state", int'(o_state), 4'b0010);
    check_eq("run_entry_run", int'(o_run), 1);
    settle(9);
    check_eq("no_early_tick", int'(o_sec), 10);
    cycle();
    check_eq("first_tick", int'(o_sec), 9);
    settle(90);
    check_eq("done_sec", int'(o_sec), 0);
    check_eq("done_state", int'(o_state), 4'b1000);
    check_eq("done_run", int'(o_run), 0);
    finish = 1'b1;
    cycle();
    finish = 1'b0;
    check_eq("finish_idle", int'(o_state), 4'b0001);

    // Pause / resume with a full second after resume.
    repeat (3) press(1);
    settle(3);
    check_eq("set30", int'(o_sec), 30);
    press(0);
    cycle();
    press(0);
    cycle();
    check_eq("pause_state", int'(o_state), 4'b0100);
    check_eq("pause_sec", int'(o_sec), 30);
    check_eq("pause_run", int'(o_run), 0);
    press(1);
    settle(3);
    check_eq("pause_up", int'(o_sec), 40);
    press(0);
    cycle();
    settle(9);
    check_eq("resume_hold", int'(o_sec), 40);
    cycle();
    check_eq("resume_tick", int'(o_sec), 39);

    // Start lands on the same edge as a tick: pause, no decrement.
    settle(7);
    press(0);
    cycle();
    check_eq("start_tick_state", int'(o_state), 4'b0100);
    check_eq("start_tick_sec", int'(o_sec), 39);

    // Up and down together cancel.
    btn_up = 1'b1;
    btn_down = 1'b1;
    cycle();
    btn_up = 1'b0;
    btn_down = 1'b0;
    settle(3);
    check_eq("updown_cancel", int'(o_sec), 39);
    repeat (4) press(2);
    settle(3);
    check_eq("pause_down_idle", int'(o_state), 4'b0001);
    check_eq("pause_down_zero", int'(o_sec), 0);

    // Saturation and floor.
    repeat (105) press(1);
    settle(3);
    check_eq("sat999", int'(o_sec), 999);
    press(1);
    settle(3);
    check_eq("sat_hold", int'(o_sec), 999);
    repeat (99) press(2);
    settle(3);
    check_eq("down9", int'(o_sec), 9);
    press(2);
    settle(3);
    check_eq("floor0", int'(o_sec), 0);
    press(0);
    settle(3);
    check_eq("start_zero", int'(o_state), 4'b0001);

    // Reset mid-RUN at 17 s.
    repeat (2) press(1);
    press(0);
    cycle();
    settle(30);
    check_eq("run17", int'(o_sec), 17);
    settle(4);
    do_reset();
    settle(2);

`ifdef COOK_DOOR_EN
    press(1);
    press(0);
    cycle();
    settle(3);
    door_open = 1'b1;
    cycle();
    check_eq("door_pause", int'(o_state), 4'b0100);
    press(0);
    settle(3);
    check_eq("door_start_blk", int'(o_state), 4'b0100);
    door_open = 1'b0;
    press(0);
    cycle();
    check_eq("door_resume", int'(o_state), 4'b0010);
    do_reset();
    settle(2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      btn_start = ($urandom_range(0, 9) == 0);
      btn_up    = ($urandom_range(0, 3) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      finish    = ($urandom_range(0, 15) == 0);
`ifdef COOK_DOOR_EN
      door_open = ($urandom_range(0, 19) == 0);
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
